// File: rtl/usb_encoder_if.sv
// usb_encoder port bundle: packet request,
// payload byte stream and encoded output stream.
interface usb_encoder_if;
  logic       start;
  logic [7:0] pkt_type;
  logic [7:0] len;
  logic [7:0] d;
  logic       d_rdy;
  logic       d_ack;
  logic [7:0] q;
  logic       q_rdy;
  logic       q_accepted;
  logic       busy;

  modport master (
    output start, pkt_type, len,
    output d, d_rdy, q_accepted,
    input  d_ack, q, q_rdy, busy
  );

  modport slave (
    input  start, pkt_type, len,
    input  d, d_rdy, q_accepted,
    output d_ack, q, q_rdy, busy
  );
endinterface

// File: rtl/usb_encoder.sv
// Host-bound framer: SYNC TYPE LEN payload CSUM,
// byte-stuffed so SYNC never appears after the first byte.
module usb_encoder #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter logic [7:0] ESC     = 8'h5A,
  parameter logic [7:0] ESC_XOR = 8'h20
) (
  input  logic         clk,
  input  logic         n_rst,
  usb_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_TYPE, S_LEN,
    S_DATA, S_CSUM, S_END
  } state_t;

  state_t     state, state_n;
  logic [7:0] typ_r, typ_n;
  logic [7:0] len_r, len_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] csum, csum_n;
  logic [7:0] hold, hold_n;
  logic [7:0] q_r, q_n;
  logic       q_rdy_r, q_rdy_n;
  logic       busy_r, busy_n;
  logic       esc_r, esc_n;
  logic       d_ack;
  logic       adv;
  logic       slot_free;
  logic [7:0] cur_b;

  assign slot_free = ~q_rdy_r | bus.q_accepted;

  always_comb begin
    cur_b = bus.d;
    unique case (state)
      S_TYPE:  cur_b = typ_r;
      S_LEN:   cur_b = len_r;
      S_CSUM:  cur_b = csum;
      default: cur_b = bus.d;
    endcase
  end

  always_comb begin
    state_n = state;
    typ_n   = typ_r;
    len_n   = len_r;
    cnt_n   = cnt;
    csum_n  = csum;
    hold_n  = hold;
    q_n     = q_r;
    q_rdy_n = q_rdy_r & ~slot_free;
    busy_n  = busy_r;
    esc_n   = esc_r;
    d_ack   = 1'b0;
    adv     = 1'b0;
    unique case (state)
      S_IDLE: if (bus.start) begin
        typ_n   = bus.pkt_type;
        len_n   = bus.len;
        busy_n  = 1'b1;
        state_n = S_SYNC;
      end
      S_SYNC: if (slot_free) begin
        q_n     = SYNC;
        q_rdy_n = 1'b1;
        csum_n  = 8'd0;
        state_n = S_TYPE;
      end
      S_END: if (slot_free) begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: if (slot_free) begin
        if (esc_r) begin
          q_n     = hold;
          q_rdy_n = 1'b1;
          esc_n   = 1'b0;
          adv     = 1'b1;
        end else if (state != S_DATA
                     || bus.d_rdy) begin
          d_ack   = (state == S_DATA);
          q_rdy_n = 1'b1;
          if (state != S_CSUM)
            csum_n = csum + cur_b;
          if (state == S_LEN)
            cnt_n = len_r;
          if (state == S_DATA)
            cnt_n = cnt - 8'd1;
          // stuffed byte is parked in hold
          if (cur_b == SYNC || cur_b == ESC) begin
            q_n    = ESC;
            hold_n = cur_b ^ ESC_XOR;
            esc_n  = 1'b1;
          end else begin
            q_n = cur_b;
            adv = 1'b1;
          end
        end
      end
    endcase
    if (adv) begin
      unique case (state)
        S_TYPE:  state_n = S_LEN;
        S_LEN:   state_n = (|len_r) ? S_DATA
                                    : S_CSUM;
        S_DATA:  if (cnt_n == 8'd0)
                   state_n = S_CSUM;
        default: state_n = S_END;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      typ_r   <= 8'd0;
      len_r   <= 8'd0;
      cnt     <= 8'd0;
      csum    <= 8'd0;
      hold    <= 8'd0;
      q_r     <= 8'd0;
      q_rdy_r <= 1'b0;
      busy_r  <= 1'b0;
      esc_r   <= 1'b0;
    end else begin
      state   <= state_n;
      typ_r   <= typ_n;
      len_r   <= len_n;
      cnt     <= cnt_n;
      csum    <= csum_n;
      hold    <= hold_n;
      q_r     <= q_n;
      q_rdy_r <= q_rdy_n;
      busy_r  <= busy_n;
      esc_r   <= esc_n;
    end
  end

  assign bus.q     = q_r;
  assign bus.q_rdy = q_rdy_r;
  assign bus.busy  = busy_r;
  assign bus.d_ack = d_ack;

endmodule

// File: tb/tb_usb_encoder.sv
// Self-checking bench for usb_encoder: randomized
// handshakes checked against a frame-level model.
module tb_usb_encoder;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  usb_encoder_if bus ();

  usb_encoder dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int acc_pct, rdy_pct;
  int stall_at, stall_len;
  int gap_at, gap_len;
  int abort_after;

  int acks, stall_viol, gap_low, held;
  int bubbles, lat, busy_lat;
  bq_t got, cons;

  function automatic bq_t model(
    input logic [7:0] t,
    input logic [7:0] l,
    input bq_t pl
  );
    bq_t body;
    bq_t o;
    int s;
    s = int'(t) + int'(l);
    body.push_back(t);
    body.push_back(l);
    foreach (pl[i]) begin
      s += int'(pl[i]);
      body.push_back(pl[i]);
    end
    body.push_back(8'(s));
    o.push_back(8'hA5);
    foreach (body[i]) begin
      if (body[i] == 8'hA5 || body[i] == 8'h5A) begin
        o.push_back(8'h5A);
        o.push_back(body[i] ^ 8'h20);
      end else begin
        o.push_back(body[i]);
      end
    end
    return o;
  endfunction

  function automatic bit same(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input bq_t a);
    string s;
    s = "";
    foreach (a[i])
      if (i < 32) s = {s, $sformatf("%02h ", a[i])};
    return s;
  endfunction

  function automatic bq_t mk_pl(input int n, input bit sp);
    bq_t p;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (sp && $urandom_range(0, 3) == 0)
        b = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h5A;
      if (!sp && (b == 8'hA5 || b == 8'h5A))
        b = 8'h11;
      p.push_back(b);
    end
    return p;
  endfunction

  task automatic set_cfg(input int acc, input int rdy);
    acc_pct = acc;
    rdy_pct = rdy;
    stall_at = 0;
    stall_len = 0;
    gap_at = 0;
    gap_len = 0;
    abort_after = 0;
  endtask

  // Drives one frame request and collects everything
  // that crosses the q and d handshakes.
  task automatic run_frame(
    input logic [7:0] t,
    input logic [7:0] l,
    input bq_t pl
  );
    int idx, stall_left, gap_left, last_it;
    bit pv_hold, seen, done, in_gap;
    logic [7:0] pv_q;
    got.delete();
    cons.delete();
    acks = 0; stall_viol = 0; gap_low = 0;
    held = 0; bubbles = 0; lat = -1;
    busy_lat = -1; last_it = 0;
    idx = 0; stall_left = stall_len;
    gap_left = gap_len;
    pv_hold = 0; pv_q = 0; seen = 0;
    done = 0; in_gap = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.pkt_type = t;
    bus.len = l;
    bus.d_rdy = 1'b0;
    bus.d = 8'($urandom);
    bus.q_accepted = 1'($urandom_range(0, 1));
    for (int it = 1; it <= 3000 && !done; it++) begin
      @(negedge clk);
      if (pv_hold && (!bus.q_rdy || bus.q !== pv_q))
        stall_viol++;
      if (bus.d_ack && bus.q_rdy && !bus.q_accepted)
        stall_viol++;
      pv_hold = bus.q_rdy && !bus.q_accepted;
      pv_q = bus.q;
      if (pv_hold) held++;
      if (in_gap && !bus.q_rdy) gap_low++;
      if (bus.q_rdy && !seen) begin
        seen = 1;
        lat = it - 1;
      end
      if (seen && bus.busy && !bus.q_rdy) bubbles++;
      if (bus.d_ack) begin
        acks++;
        cons.push_back(bus.d);
        idx++;
      end
      if (bus.q_rdy && bus.q_accepted) begin
        got.push_back(bus.q);
        last_it = it;
      end
      if (it > 1 && !bus.busy) begin
        done = 1;
        busy_lat = it - last_it;
      end
      if (abort_after > 0 && got.size() >= abort_after)
        done = 1;
      if (!done) begin
        @(posedge clk); #1;
        if (bus.busy) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.pkt_type = 8'($urandom);
          bus.len = 8'($urandom);
        end else begin
          bus.start = 1'b0;
        end
        bus.q_accepted = $urandom_range(0, 99) < acc_pct;
        if (stall_left > 0 && idx == stall_at) begin
          bus.q_accepted = 1'b0;
          stall_left--;
        end
        in_gap = 0;
        bus.d_rdy = $urandom_range(0, 99) < rdy_pct;
        if (gap_left > 0 && idx == gap_at) begin
          bus.d_rdy = 1'b0;
          gap_left--;
          in_gap = 1;
        end
        bus.d = (idx < pl.size()) ? pl[idx]
                                  : 8'($urandom);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout type=%02h len=%0d bytes=%0d",
               t, l, got.size());
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.pkt_type = 8'h00;
    bus.len = 8'h00;
    bus.d = 8'h00;
    bus.d_rdy = 1'b1;
    bus.q_accepted = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.q !== 8'h00) begin
      errors++;
      $display("FAIL reset_q got %02h want 00", bus.q);
    end
    checks++;
    if (bus.q_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got q_rdy=%b busy=%b want 0 0",
               bus.q_rdy, bus.busy);
    end
    checks++;
    if (bus.d_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_d_ack got %b want 0", bus.d_ack);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.q_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags got q_rdy=%b busy=%b want 0 0",
               bus.q_rdy, bus.busy);
    end
  endtask

  task automatic test_basic();
    bq_t pl, lit;
    pl = {8'h10, 8'h20};
    lit = {8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    set_cfg(100, 100);
    run_frame(8'h01, 8'h02, pl);
    checks++;
    if (!same(got, lit)) begin
      errors++;
      $display("FAIL basic_stream got %s want %s",
               fmt(got), fmt(lit));
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL basic_latency got %0d want 2", lat);
    end
    checks++;
    if (busy_lat !== 1) begin
      errors++;
      $display("FAIL basic_busy_fall got %0d want 1", busy_lat);
    end
    checks++;
    if (acks !== 2 || !same(cons, pl)) begin
      errors++;
      $display("FAIL basic_d_ack got %0d acks %s want 2 acks %s",
               acks, fmt(cons), fmt(pl));
    end
    checks++;
    if (bubbles !== 0) begin
      errors++;
      $display("FAIL basic_throughput got %0d gaps want 0", bubbles);
    end
  endtask

  task automatic test_escape();
    bq_t pl, lit;
    pl = {8'hA5};
    lit = {8'hA5, 8'h02, 8'h01, 8'h5A, 8'h85, 8'hA8};
    set_cfg(100, 100);
    run_frame(8'h02, 8'h01, pl);
    checks++;
    if (!same(got, lit)) begin
      errors++;
      $display("FAIL escape_stream got %s want %s",
               fmt(got), fmt(lit));
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL escape_d_ack got %0d want 1", acks);
    end
  endtask

  task automatic test_len0();
    bq_t pl, lit;
    lit = {8'hA5, 8'h5A, 8'h7A, 8'h00, 8'h5A, 8'h7A};
    set_cfg(100, 100);
    run_frame(8'h5A, 8'h00, pl);
    checks++;
    if (!same(got, lit)) begin
      errors++;
      $display("FAIL len0_stream got %s want %s",
               fmt(got), fmt(lit));
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL len0_d_ack got %0d want 0", acks);
    end
  endtask

  task automatic test_stall();
    bq_t pl, want;
    pl = mk_pl(6, 1'b1);
    want = model(8'h33, 8'd6, pl);
    set_cfg(100, 100);
    stall_at = 3;
    stall_len = 5;
    run_frame(8'h33, 8'd6, pl);
    checks++;
    if (!same(got, want)) begin
      errors++;
      $display("FAIL stall_stream got %s want %s",
               fmt(got), fmt(want));
    end
    checks++;
    if (stall_viol !== 0 || held !== 5) begin
      errors++;
      $display("FAIL stall_hold got viol=%0d held=%0d want 0 5",
               stall_viol, held);
    end
    checks++;
    if (!same(cons, pl)) begin
      errors++;
      $display("FAIL stall_consumed got %s want %s",
               fmt(cons), fmt(pl));
    end
  endtask

  task automatic test_gap();
    bq_t pl, want;
    pl = mk_pl(5, 1'b0);
    want = model(8'h44, 8'd5, pl);
    set_cfg(100, 100);
    gap_at = 2;
    gap_len = 3;
    run_frame(8'h44, 8'd5, pl);
    checks++;
    if (!same(got, want)) begin
      errors++;
      $display("FAIL gap_stream got %s want %s",
               fmt(got), fmt(want));
    end
    checks++;
    if (gap_low !== 2) begin
      errors++;
      $display("FAIL gap_q_rdy got %0d low want 2", gap_low);
    end
    checks++;
    if (!same(cons, pl)) begin
      errors++;
      $display("FAIL gap_consumed got %s want %s",
               fmt(cons), fmt(pl));
    end
  endtask

  task automatic test_reset_abort();
    bq_t pl, lit;
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    set_cfg(100, 0);
    abort_after = 3;
    run_frame(8'h07, 8'd4, pl);
    bus.start = 1'b0;
    n_rst = 1'b0;
    #2;
    checks++;
    if (bus.q !== 8'h00 || bus.q_rdy !== 1'b0
        || bus.busy !== 1'b0 || bus.d_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got q=%02h q_rdy=%b busy=%b d_ack=%b want 0",
               bus.q, bus.q_rdy, bus.busy, bus.d_ack);
    end
    @(negedge clk);
    n_rst = 1'b1;
    pl.delete();
    lit = {8'hA5, 8'h03, 8'h00, 8'h03};
    set_cfg(100, 100);
    run_frame(8'h03, 8'h00, pl);
    checks++;
    if (!same(got, lit)) begin
      errors++;
      $display("FAIL abort_restart got %s want %s",
               fmt(got), fmt(lit));
    end
  endtask

  task automatic test_len255();
    bq_t pl, want;
    pl = mk_pl(255, 1'b1);
    want = model(8'hA5, 8'd255, pl);
    set_cfg(100, 100);
    run_frame(8'hA5, 8'd255, pl);
    checks++;
    if (!same(got, want)) begin
      errors++;
      $display("FAIL len255_stream got %0d bytes want %0d",
               got.size(), want.size());
    end
    checks++;
    if (acks !== 255 || bubbles !== 0) begin
      errors++;
      $display("FAIL len255_flow got acks=%0d gaps=%0d want 255 0",
               acks, bubbles);
    end
  endtask

  task automatic test_back_to_back();
    bq_t pl, want;
    logic [7:0] t, l;
    for (int f = 0; f < 20; f++) begin
      l = 8'($urandom_range(0, 24));
      t = ($urandom_range(0, 3) == 0) ? 8'h5A
                                      : 8'($urandom);
      pl = mk_pl(int'(l), 1'b1);
      want = model(t, l, pl);
      set_cfg($urandom_range(30, 100),
              $urandom_range(30, 100));
      run_frame(t, l, pl);
      checks++;
      if (!same(got, want)) begin
        errors++;
        $display("FAIL b2b_stream frame %0d got %s want %s",
                 f, fmt(got), fmt(want));
      end
      checks++;
      if (!same(cons, pl) || acks !== int'(l)) begin
        errors++;
        $display("FAIL b2b_consumed frame %0d got %0d acks want %0d",
                 f, acks, l);
      end
      checks++;
      if (stall_viol !== 0) begin
        errors++;
        $display("FAIL b2b_hold frame %0d got %0d viol want 0",
                 f, stall_viol);
      end
      checks++;
      if (lat !== 2 || busy_lat !== 1) begin
        errors++;
        $display("FAIL b2b_timing frame %0d got lat=%0d busy=%0d want 2 1",
                 f, lat, busy_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_len0();
    test_stall();
    test_gap();
    test_reset_abort();
    test_len255();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
